dwa_selector18: RTL
===================

Name: dwa_selector18

Overview:
- Data-weighted-averaging element selector for the 18-unit-element DAC core.
- Sits directly upstream of the 18-input transition detector and produces its 18-bit SV selection vector.
- Converts a 0..18 code into an 18-bit unit-element selection vector by rotating a start pointer across the array, so mismatch errors are first-order shaped.
- Also supports a plain thermometer mode for bring-up and a pointer clear for calibration.

Parameters:
N, 18, number of unit elements (selection vector width); the design and test plan are fixed at 18.
CW, 5, code input width; must satisfy 2^CW > N.

Ports:
clk  input  1  system clock, rising-edge.
rstn  input  1  asynchronous reset, active-low (0 = reset).
code  input  CW  requested number of active elements, 0..N.
code_valid  input  1  code is sampled on a rising clk edge when high.
mode  input  1  0 = thermometer, 1 = DWA rotation.
ptr_clr  input  1  synchronous clear of the rotation pointer.
SV  output  N  registered element selection vector, feeds transition detector.
sv_valid  output  1  one-cycle pulse; SV updated this cycle.
ptr  output  5  current rotation pointer, 0..N-1 (debug/observation).
sat_err  output  1  sticky flag; set when a code > N was received.

Behaviour:
- Reset (rstn=0, asynchronous, any time including mid-stream): SV=0, sv_valid=0, ptr=0, sat_err=0. All registers are cleared immediately and held while rstn=0. First sample is taken on the first rising edge after rstn releases.
- Code saturation: effective code c = min(code, N). If code > N while code_valid=1, sat_err is set on that edge and stays 1 until reset.
- Latency: SV and sv_valid are registered. Code sampled at edge k appears on SV after edge k, i.e. 1-cycle latency.
- code_valid=0: SV holds its previous value, sv_valid=0, ptr unchanged. The DAC keeps its last selection.
- Base pointer b = 0 if ptr_clr=1, else ptr.
- mode=1 (DWA), on code_valid=1:
  - SV bit i = 1 iff ((i - b) mod N) < c, i.e. c contiguous ones starting at bit b and wrapping past bit N-1 to bit 0.
  - ptr <= (b + c) mod N. Compute with a single conditional subtract of N; b + c ≤ 35 fits in 6 bits.
- mode=0 (thermometer), on code_valid=1:
  - SV bit i = 1 iff i < c.
  - ptr <= 0 if ptr_clr=1, else unchanged.
- Boundaries:
  - c = 0 gives SV = all zeros; ptr unchanged (or 0 if ptr_clr).
  - c = N gives SV = all ones; ptr unchanged (or 0 if ptr_clr).
  - Wrap-around is exact modulo N; ptr never reaches N.
- ptr_clr=1 with code_valid=0: ptr <= 0 on that edge; SV holds.
- ptr_clr=1 with code_valid=1: the clear applies before selection for the same sample (base 0), as defined above.
- sv_valid = registered code_valid, one pulse per accepted code.
- mode may change between any two samples. The new mode applies to the sample on which it is seen; ptr is not reset by a mode change.
- Fully synchronous to clk apart from the reset. No combinational path from inputs to outputs.

Test Plan:
- Reset mid-stream: rstn pulled low while SV=18'h3FFFF, ptr=7 -> SV=0, ptr=0, sv_valid=0, sat_err=0 immediately, without waiting for a clk edge.
- DWA wrap: mode=1, four consecutive code=5 from reset -> SV sequence 18'h0001F, 18'h003E0, 18'h07C00, 18'h38003; ptr 5, 10, 15, 2.
- Extremes: mode=1 at ptr=4 -> code=0 gives SV=0 and ptr=4; code=18 gives SV=18'h3FFFF and ptr=4.
- Saturation: mode=1 at ptr=3, code=25 -> SV=18'h3FFFF, ptr=3, sat_err=1 and remaining 1 after later legal codes until rstn=0.
- Thermometer mode and ptr_clr:
  - mode=0 at ptr=9, code=3 -> SV=18'h00007, ptr stays 9.
  - Then mode=1, ptr_clr=1, code=2 -> SV=18'h00003, ptr=2.
- Hold/latency: code_valid pulsed once with code=4 at ptr=16 -> one cycle later SV=18'h30003 and sv_valid=1 for exactly one cycle; SV stays 18'h30003 for the following idle cycles.

Source files
------------

// File: rtl/dwa_selector18_if.sv
// Handshake/data bundle between the code source and the DWA element selector.
// The master drives codes and control; the slave (selector) returns the
// selection vector, its valid pulse, the rotation pointer and the sticky
// saturation flag.
interface dwa_selector18_if #(
  parameter int N  = 18,
  parameter int CW = 5
);
  logic [CW-1:0] code;
  logic          code_valid;
  logic          mode;
  logic          ptr_clr;
  logic [N-1:0]  SV;
  logic          sv_valid;
  logic [4:0]    ptr;
  logic          sat_err;

  modport master (
    output code, code_valid, mode, ptr_clr,
    input  SV, sv_valid, ptr, sat_err
  );

  modport slave (
    input  code, code_valid, mode, ptr_clr,
    output SV, sv_valid, ptr, sat_err
  );
endinterface

// File: rtl/dwa_selector18.sv
// Data-weighted-averaging element selector for the 18-unit-element DAC.
// Turns a 0..N code into an N-bit selection vector. In DWA mode the active
// block of elements starts at a rotating pointer and wraps around the array,
// so every element is used equally often and mismatch is first-order shaped.
// Thermometer mode always selects from bit 0 and is meant for bring-up.
// All outputs are registered; there is no input-to-output combinational path.
module dwa_selector18 #(
  parameter int N  = 18,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rstn,
  dwa_selector18_if.slave bus
);

  logic [CW-1:0]  c_eff;
  logic           over;
  logic [4:0]     base;
  logic [N-1:0]   therm;
  logic [2*N-1:0] rot_wide;
  logic [N-1:0]   sel_nxt;
  logic [5:0]     sum;
  logic [4:0]     ptr_nxt;

  logic [N-1:0]   sv_q;
  logic           sv_valid_q;
  logic [4:0]     ptr_q;
  logic           sat_q;

  // Saturate the code, pick the base pointer, build the selection and the next pointer
  always_comb begin
    over     = (bus.code > CW'(N));
    c_eff    = over ? CW'(N) : bus.code;
    // A pointer clear takes effect before the selection of the same sample.
    base     = bus.ptr_clr ? 5'd0 : ptr_q;
    therm    = '0;
    for (int i = 0; i < N; i++) begin
      therm[i] = (CW'(i) < c_eff);
    end
    // Shifting the thermometer into a double-width word and folding the upper
    // half back onto the lower half gives the wrap past bit N-1 to bit 0.
    rot_wide = {{N{1'b0}}, therm} << base;
    sel_nxt  = bus.mode ? (rot_wide[N-1:0] | rot_wide[2*N-1:N]) : therm;
    // base + c is at most 35, so one conditional subtract of N is exact modulo N.
    sum      = 6'(base) + 6'(c_eff);
    ptr_nxt  = base;
    if (bus.code_valid && bus.mode) begin
      if (sum >= 6'(N)) begin
        ptr_nxt = 5'(sum - 6'(N));
      end else begin
        ptr_nxt = sum[4:0];
      end
    end
  end

  // Output and pointer registers; SV holds its last value while no code is offered
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sv_q       <= '0;
      sv_valid_q <= 1'b0;
      ptr_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      sv_valid_q <= bus.code_valid;
      ptr_q      <= ptr_nxt;
      if (bus.code_valid) begin
        sv_q <= sel_nxt;
      end
      if (bus.code_valid && over) begin
        sat_q <= 1'b1;
      end
    end
  end

  assign bus.SV       = sv_q;
  assign bus.sv_valid = sv_valid_q;
  assign bus.ptr      = ptr_q;
  assign bus.sat_err  = sat_q;

endmodule
